// File: rtl/decode_stage.sv
// decode_stage -- single-entry decode stage for a small RV32 subset
// (add, sub, addi, bne, lui).
//
// Accepts one instruction per cycle from fetch over a valid/ready handshake,
// decodes it combinationally and holds the result in an output register
// presented to execute over a second valid/ready handshake. Anything outside
// the supported subset is passed downstream flagged as illegal with all
// other control bits cleared.
//
// Optional feature: define DECODE_SCOREBOARD_EN to build a 32-entry pending
// write scoreboard and the read-after-write hazard stall. Without it the
// stage never stalls on hazards and wb_valid/wb_rd are ignored.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   if_valid/if_ready     fetch handshake (if_ready independent of if_valid)
//   if_inst, if_pc        instruction word and its PC
//   flush                 drop held and incoming instruction (redirect)
//   de_valid/de_ready     execute handshake
//   de_pc, de_imm         registered PC and sign-extended immediate
//   de_rs1/de_rs2/de_rd   register specifiers (unused ones are 0)
//   de_sub, de_use_imm, de_is_bne, de_is_lui, de_wen, de_illegal
//                         decoded control bundle
//   wb_valid, wb_rd       writeback retirement, clears a pending bit
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic            de_valid,
  input  logic            de_ready,
  output logic [XLEN-1:0] de_pc,
  output logic [XLEN-1:0] de_imm,
  output logic [4:0]      de_rs1,
  output logic [4:0]      de_rs2,
  output logic [4:0]      de_rd,
  output logic            de_sub,
  output logic            de_use_imm,
  output logic            de_is_bne,
  output logic            de_is_lui,
  output logic            de_wen,
  output logic            de_illegal,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd
);

  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LUI    = 5'b01101;

  // Widen a signed 32-bit immediate to the datapath width.
  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  // ---------------- combinational decode of if_inst ----------------
  logic [4:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            legal;
  logic            use_rs1;
  logic            use_rs2;
  logic            dec_sub;
  logic            dec_use_imm;
  logic            dec_is_bne;
  logic            dec_is_lui;
  logic            dec_wen;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic [4:0]      dec_rd;
  logic [XLEN-1:0] dec_imm;

  assign opcode = if_inst[6:2];
  assign funct3 = if_inst[14:12];
  assign funct7 = if_inst[31:25];

  always_comb begin
    legal       = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    dec_sub     = 1'b0;
    dec_use_imm = 1'b0;
    dec_is_bne  = 1'b0;
    dec_is_lui  = 1'b0;
    dec_wen     = 1'b0;
    dec_rs1     = 5'd0;
    dec_rs2     = 5'd0;
    dec_rd      = 5'd0;
    dec_imm     = '0;
    // Fields are only populated for legal encodings, so an illegal
    // instruction leaves everything at zero apart from de_illegal.
    if (if_inst[1:0] == 2'b11) begin
      case (opcode)
        OPC_OP: begin
          if (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
            legal   = 1'b1;
            dec_sub = funct7[5];
            dec_rs1 = if_inst[19:15];
            dec_rs2 = if_inst[24:20];
            dec_rd  = if_inst[11:7];
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            dec_wen = 1'b1;
          end
        end
        OPC_OPIMM: begin
          if (funct3 == 3'b000) begin
            legal       = 1'b1;
            dec_rs1     = if_inst[19:15];
            dec_rd      = if_inst[11:7];
            use_rs1     = 1'b1;
            dec_use_imm = 1'b1;
            dec_wen     = 1'b1;
            dec_imm     = sext32({{20{if_inst[31]}}, if_inst[31:20]});
          end
        end
        OPC_BRANCH: begin
          if (funct3 == 3'b001) begin
            legal      = 1'b1;
            dec_is_bne = 1'b1;
            dec_rs1    = if_inst[19:15];
            dec_rs2    = if_inst[24:20];
            use_rs1    = 1'b1;
            use_rs2    = 1'b1;
            dec_imm    = sext32({{19{if_inst[31]}}, if_inst[31], if_inst[7],
                                 if_inst[30:25], if_inst[11:8], 1'b0});
          end
        end
        OPC_LUI: begin
          legal       = 1'b1;
          dec_is_lui  = 1'b1;
          dec_rd      = if_inst[11:7];
          dec_use_imm = 1'b1;
          dec_wen     = 1'b1;
          dec_imm     = sext32({if_inst[31:12], 12'b0});
        end
        default: legal = 1'b0;
      endcase
    end
    // Writes to x0 are architecturally discarded; never mark them pending.
    if (dec_rd == 5'd0) dec_wen = 1'b0;
  end

  // ---------------- handshake ----------------
  logic            hazard;
  logic            accept;
  logic            out_xfer;

  logic            de_valid_q,   de_valid_d;
  logic [XLEN-1:0] de_pc_q,      de_pc_d;
  logic [XLEN-1:0] de_imm_q,     de_imm_d;
  logic [4:0]      de_rs1_q,     de_rs1_d;
  logic [4:0]      de_rs2_q,     de_rs2_d;
  logic [4:0]      de_rd_q,      de_rd_d;
  logic            de_sub_q,     de_sub_d;
  logic            de_use_imm_q, de_use_imm_d;
  logic            de_is_bne_q,  de_is_bne_d;
  logic            de_is_lui_q,  de_is_lui_d;
  logic            de_wen_q,     de_wen_d;
  logic            de_illegal_q, de_illegal_d;

  // A flush always accepts so the redirected fetch stream is not held up;
  // the word taken in that cycle is simply discarded.
  assign if_ready = flush || ((!de_valid_q || de_ready) && !hazard);
  assign accept   = if_valid && if_ready;
  assign out_xfer = de_valid_q && de_ready;

  always_comb begin
    de_valid_d   = de_valid_q;
    de_pc_d      = de_pc_q;
    de_imm_d     = de_imm_q;
    de_rs1_d     = de_rs1_q;
    de_rs2_d     = de_rs2_q;
    de_rd_d      = de_rd_q;
    de_sub_d     = de_sub_q;
    de_use_imm_d = de_use_imm_q;
    de_is_bne_d  = de_is_bne_q;
    de_is_lui_d  = de_is_lui_q;
    de_wen_d     = de_wen_q;
    de_illegal_d = de_illegal_q;
    if (flush) begin
      de_valid_d = 1'b0;
    end else if (accept) begin
      de_valid_d   = 1'b1;
      de_pc_d      = if_pc;
      de_imm_d     = dec_imm;
      de_rs1_d     = dec_rs1;
      de_rs2_d     = dec_rs2;
      de_rd_d      = dec_rd;
      de_sub_d     = dec_sub;
      de_use_imm_d = dec_use_imm;
      de_is_bne_d  = dec_is_bne;
      de_is_lui_d  = dec_is_lui;
      de_wen_d     = dec_wen;
      de_illegal_d = !legal;
    end else if (out_xfer) begin
      de_valid_d = 1'b0;
    end
  end

  // ---------------- output register stage ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      de_valid_q   <= 1'b0;
      de_pc_q      <= '0;
      de_imm_q     <= '0;
      de_rs1_q     <= 5'd0;
      de_rs2_q     <= 5'd0;
      de_rd_q      <= 5'd0;
      de_sub_q     <= 1'b0;
      de_use_imm_q <= 1'b0;
      de_is_bne_q  <= 1'b0;
      de_is_lui_q  <= 1'b0;
      de_wen_q     <= 1'b0;
      de_illegal_q <= 1'b0;
    end else begin
      de_valid_q   <= de_valid_d;
      de_pc_q      <= de_pc_d;
      de_imm_q     <= de_imm_d;
      de_rs1_q     <= de_rs1_d;
      de_rs2_q     <= de_rs2_d;
      de_rd_q      <= de_rd_d;
      de_sub_q     <= de_sub_d;
      de_use_imm_q <= de_use_imm_d;
      de_is_bne_q  <= de_is_bne_d;
      de_is_lui_q  <= de_is_lui_d;
      de_wen_q     <= de_wen_d;
      de_illegal_q <= de_illegal_d;
    end
  end

  assign de_valid   = de_valid_q;
  assign de_pc      = de_pc_q;
  assign de_imm     = de_imm_q;
  assign de_rs1     = de_rs1_q;
  assign de_rs2     = de_rs2_q;
  assign de_rd      = de_rd_q;
  assign de_sub     = de_sub_q;
  assign de_use_imm = de_use_imm_q;
  assign de_is_bne  = de_is_bne_q;
  assign de_is_lui  = de_is_lui_q;
  assign de_wen     = de_wen_q;
  assign de_illegal = de_illegal_q;

`ifdef DECODE_SCOREBOARD_EN
  // ---------------- pending-write scoreboard ----------------
  logic [31:0] pend_q, pend_d;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic        rs1_hit;
  logic        rs2_hit;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (out_xfer && de_wen_q) set_vec[de_rd_q] = 1'b1;
    if (wb_valid)             clr_vec[wb_rd]   = 1'b1;
    // Applying the set after the clear makes a same-cycle issue win over
    // a retirement of the same register.
    pend_d    = (pend_q & ~clr_vec) | set_vec;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  // Hazard is evaluated from if_inst alone, without if_valid, so that
  // if_ready never depends on if_valid; when if_valid is low no transfer
  // happens, so the value is harmless. The held instruction counts even if
  // it leaves this cycle, and writeback is not bypassed.
  always_comb begin
    rs1_hit = use_rs1 && (dec_rs1 != 5'd0) &&
              (pend_q[dec_rs1] || (de_valid_q && de_wen_q && de_rd_q == dec_rs1));
    rs2_hit = use_rs2 && (dec_rs2 != 5'd0) &&
              (pend_q[dec_rs2] || (de_valid_q && de_wen_q && de_rd_q == dec_rs2));
    hazard  = rs1_hit || rs2_hit;
  end
`else
  logic unused_sb;
  assign hazard    = 1'b0;
  assign unused_sb = ^{wb_valid, wb_rd, use_rs1, use_rs2};
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage -- directed bench for decode_stage: a table of single
// instruction decodes plus hand-written multi-cycle sequences (hazard stall,
// output back-pressure, flush, reset while stalled). Expectations for the
// hazard sequences follow DECODE_SCOREBOARD_EN as seen by this file.
module tb_decode_stage;

`ifdef DECODE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        flush;
  logic        de_valid;
  logic        de_ready;
  logic [31:0] de_pc;
  logic [31:0] de_imm;
  logic [4:0]  de_rs1, de_rs2, de_rd;
  logic        de_sub, de_use_imm, de_is_bne, de_is_lui, de_wen, de_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [5:0]  ctl;

  int n_cmp = 0;
  int n_err = 0;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .flush(flush),
    .de_valid(de_valid), .de_ready(de_ready), .de_pc(de_pc), .de_imm(de_imm),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rd(de_rd),
    .de_sub(de_sub), .de_use_imm(de_use_imm), .de_is_bne(de_is_bne),
    .de_is_lui(de_is_lui), .de_wen(de_wen), .de_illegal(de_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  // {sub, use_imm, is_bne, is_lui, wen, illegal}
  assign ctl = {de_sub, de_use_imm, de_is_bne, de_is_lui, de_wen, de_illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [5:0]  ctl;
    logic [1:0]  chk;   // [1]: rs1/rd/imm meaningful, [0]: rs2 meaningful
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_valid = 1'b0;
    if_inst  = 32'h0;
    if_pc    = 32'h0;
    flush    = 1'b0;
    de_ready = 1'b1;
    wb_valid = 1'b0;
    wb_rd    = 5'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    if_valid = 1'b1;
    if_inst  = inst;
    if_pc    = pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            inst          pc           imm          rs1   rs2   rd    ctl        chk
    vecs[0]  = '{32'h00500093, 32'h00001000, 32'h00000005, 5'd0, 5'd0, 5'd1, 6'b010010, 2'b10}; // addi x1,x0,5
    vecs[1]  = '{32'h40208133, 32'h00001004, 32'h00000000, 5'd1, 5'd2, 5'd2, 6'b100010, 2'b11}; // sub x2,x1,x2
    vecs[2]  = '{32'h02208133, 32'h00001008, 32'h00000000, 5'd0, 5'd0, 5'd0, 6'b000001, 2'b00}; // funct7 0000001
    vecs[3]  = '{32'hFE009EE3, 32'h0000100C, 32'hFFFFFFFC, 5'd1, 5'd0, 5'd0, 6'b001000, 2'b11}; // bne x1,x0,-4
    vecs[4]  = '{32'h123452B7, 32'h00001010, 32'h12345000, 5'd0, 5'd0, 5'd5, 6'b010110, 2'b11}; // lui x5
    vecs[5]  = '{32'hFFFFF0B7, 32'h00001014, 32'hFFFFF000, 5'd0, 5'd0, 5'd1, 6'b010110, 2'b11}; // lui x1,0xfffff
    vecs[6]  = '{32'h00208033, 32'h00001018, 32'h00000000, 5'd1, 5'd2, 5'd0, 6'b000000, 2'b11}; // add x0 -> no wen
    vecs[7]  = '{32'h001081B3, 32'h0000101C, 32'h00000000, 5'd1, 5'd1, 5'd3, 6'b000010, 2'b11}; // add x3,x1,x1
    vecs[8]  = '{32'hFFF10213, 32'h00001020, 32'hFFFFFFFF, 5'd2, 5'd0, 5'd4, 6'b010010, 2'b10}; // addi x4,x2,-1
    vecs[9]  = '{32'h00000001, 32'h00001024, 32'h00000000, 5'd0, 5'd0, 5'd0, 6'b000001, 2'b00}; // bits[1:0]!=11
    vecs[10] = '{32'h00002003, 32'h00001028, 32'h00000000, 5'd0, 5'd0, 5'd0, 6'b000001, 2'b00}; // load opcode
    vecs[11] = '{32'h0020C1B3, 32'h0000102C, 32'h00000000, 5'd0, 5'd0, 5'd0, 6'b000001, 2'b00}; // xor
    vecs[12] = '{32'h00102093, 32'h00001030, 32'h00000000, 5'd0, 5'd0, 5'd0, 6'b000001, 2'b00}; // slti
    vecs[13] = '{32'h00000063, 32'h00001034, 32'h00000000, 5'd0, 5'd0, 5'd0, 6'b000001, 2'b00}; // beq

    // Reset dominates a concurrent flush and offered instruction.
    idle_inputs();
    reset = 1'b1;
    drive(32'h00500093, 32'h0000ABC0);
    flush = 1'b1;
    tick();
    tick();
    mid();
    check("rst de_valid", de_valid, 1'b0);
    check("rst ctl", ctl, 6'b0);
    check("rst de_pc", de_pc, 32'h0);
    check("rst de_imm", de_imm, 32'h0);
    check("rst regs", {de_rs1, de_rs2, de_rd}, 15'h0);
    tick();

    // Table: one instruction per reset window, checked the cycle after acceptance.
    for (int i = 0; i < NV; i++) begin
      do_reset();
      drive(vecs[i].inst, vecs[i].pc);
      mid();
      check($sformatf("v%0d if_ready", i), if_ready, 1'b1);
      tick();
      idle_inputs();
      mid();
      check($sformatf("v%0d de_valid", i), de_valid, 1'b1);
      check($sformatf("v%0d ctl", i), ctl, vecs[i].ctl);
      check($sformatf("v%0d de_pc", i), de_pc, vecs[i].pc);
      if (vecs[i].chk[1]) begin
        check($sformatf("v%0d de_rs1", i), de_rs1, vecs[i].rs1);
        check($sformatf("v%0d de_rd", i), de_rd, vecs[i].rd);
        if (vecs[i].ctl[4] || vecs[i].ctl[3])
          check($sformatf("v%0d de_imm", i), de_imm, vecs[i].imm);
      end
      if (vecs[i].chk[0])
        check($sformatf("v%0d de_rs2", i), de_rs2, vecs[i].rs2);
    end

    // RAW hazard: addi x1 followed directly by add x3,x1,x1.
    do_reset();
    drive(32'h00500093, 32'h00000100);
    mid();
    check("raw first if_ready", if_ready, 1'b1);
    tick();
    drive(32'h001081B3, 32'h00000104);
    mid();
    check("raw held rd", de_rd, 5'd1);
`ifdef DECODE_SCOREBOARD_EN
    check("raw stall held", if_ready, 1'b0);
    tick();
    mid();
    check("raw stall pending", if_ready, 1'b0);
    check("raw bubble de_valid", de_valid, 1'b0);
    tick();
    wb_valid = 1'b1;
    wb_rd    = 5'd1;
    mid();
    check("raw no wb bypass", if_ready, 1'b0);
    tick();
    wb_valid = 1'b0;
    mid();
    check("raw released", if_ready, 1'b1);
    tick();
`else
    check("raw no stall", if_ready, 1'b1);
    tick();
`endif
    if_valid = 1'b0;
    mid();
    check("raw add de_valid", de_valid, 1'b1);
    check("raw add de_rd", de_rd, 5'd3);

    // Output back-pressure: addi held three cycles while lui waits.
    do_reset();
    de_ready = 1'b0;
    drive(32'h00500093, 32'h00000100);
    tick();
    drive(32'h000002B7, 32'h00000104);
    for (int k = 0; k < 3; k++) begin
      mid();
      check($sformatf("stall%0d de_valid", k), de_valid, 1'b1);
      check($sformatf("stall%0d state", k), {de_rd, de_imm, de_pc, ctl},
            {5'd1, 32'h5, 32'h100, 6'b010010});
      check($sformatf("stall%0d if_ready", k), if_ready, 1'b0);
      tick();
    end
    de_ready = 1'b1;
    mid();
    check("stall release if_ready", if_ready, 1'b1);
    tick();
    if_valid = 1'b0;
    mid();
    check("stall next de_valid", de_valid, 1'b1);
    check("stall next state", {de_rd, de_pc, ctl}, {5'd5, 32'h104, 6'b010110});

    // Flush while holding bne with addi x1 offered: both dropped.
    do_reset();
    de_ready = 1'b0;
    drive(32'hFE009EE3, 32'h00000200);
    tick();
    drive(32'h00500093, 32'h00000204);
    flush = 1'b1;
    mid();
    check("flush held bne", ctl, 6'b001000);
    check("flush if_ready", if_ready, 1'b1);
    tick();
    flush    = 1'b0;
    if_valid = 1'b0;
    de_ready = 1'b1;
    mid();
    check("flush de_valid", de_valid, 1'b0);
    drive(32'h001081B3, 32'h00000208);
    mid();
    check("flush no pending x1", if_ready, 1'b1);
    tick();
    if_valid = 1'b0;
    mid();
    check("flush after add rd", {de_valid, de_rd}, {1'b1, 5'd3});

    // Flush with de_ready=1 still completes the held addi x1.
    do_reset();
    de_ready = 1'b0;
    drive(32'h00500093, 32'h00000300);
    tick();
    if_valid = 1'b0;
    flush    = 1'b1;
    de_ready = 1'b1;
    tick();
    flush = 1'b0;
    drive(32'h001081B3, 32'h00000304);
    mid();
    check("flushx de_valid", de_valid, 1'b0);
    check("flushx pending x1", if_ready, !SB);
    wb_valid = 1'b1;
    wb_rd    = 5'd1;
    if_valid = 1'b0;
    tick();
    wb_valid = 1'b0;
    drive(32'h001081B3, 32'h00000304);
    mid();
    check("flushx cleared", if_ready, 1'b1);

    // Reset while stalled with x1 and x3 pending.
    do_reset();
    drive(32'h00500093, 32'h00000400);
    tick();
    drive(32'h000001B7, 32'h00000404);
    tick();
    drive(32'h000002B7, 32'h00000408);
    tick();
    de_ready = 1'b0;
    drive(32'h00118233, 32'h0000040C);
    mid();
    check("rstall stalled", if_ready, 1'b0);
    check("rstall held rd", {de_valid, de_rd}, {1'b1, 5'd5});
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mid();
    check("rstall de_valid", de_valid, 1'b0);
    check("rstall de_rd", de_rd, 5'd0);
    check("rstall if_ready", if_ready, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
